// File: rtl/wc_z_serializer.sv
// wc_z_serializer: buffers LANES x ZW result frames and sends them one lane per beat over a ZW-bit valid/ready bus.
// Define WC_Z_PARITY_EN to add the out_par even-parity output.
module wc_z_serializer #(
   parameter int LANES = 10,
   parameter int ZW    = 5,
   parameter int DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [LANES*ZW-1:0] in_z,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ZW-1:0]       out_data,
`ifdef WC_Z_PARITY_EN
   output logic                out_par,
`endif
   output logic [3:0]          out_lane,
   output logic                out_last
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PMAX = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CMAX = CW'(DEPTH);
   localparam logic [3:0]    LAST = 4'(LANES - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t state, state_n;
   logic [LANES*ZW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [3:0] lane_cnt;
   logic push, beat, pop;

   assign push = in_valid && in_ready;
   assign beat = out_valid && out_ready;
   assign pop = beat && out_last;

   always_comb begin
      state_n = state;
      in_ready = !rst && (count < CMAX);
      out_valid = count != '0;
      out_lane = lane_cnt;
      out_last = out_valid && (lane_cnt == LAST);
      // data is forced to zero when nothing is buffered so idle pads stay quiet
      out_data = out_valid ? mem[rd_ptr][lane_cnt*ZW +: ZW] : '0;
      state_n = (state == IDLE) ? (push ? SEND : IDLE)
                                : ((pop && !push && count == CW'(1)) ? IDLE : SEND);
   end

`ifdef WC_Z_PARITY_EN
   assign out_par = ^out_data;
`endif

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_z;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         lane_cnt <= '0;
      end else begin
         state <= state_n;
         if (push) wr_ptr <= (wr_ptr == PMAX) ? '0 : wr_ptr + 1'b1;
         if (pop) rd_ptr <= (rd_ptr == PMAX) ? '0 : rd_ptr + 1'b1;
         if (beat) lane_cnt <= pop ? 4'd0 : lane_cnt + 4'd1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_wc_z_serializer.sv
// tb_wc_z_serializer: directed vector bench for wc_z_serializer (out_par checked when WC_Z_PARITY_EN is defined).
module tb_wc_z_serializer;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
   logic [49:0] in_z = '0;
   logic in_ready, out_valid, out_last;
   logic [4:0] out_data;
   logic [3:0] out_lane;
`ifdef WC_Z_PARITY_EN
   logic out_par;
`endif

   wc_z_serializer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef WC_Z_PARITY_EN
      .out_par(out_par),
`endif
      .out_lane(out_lane), .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic iv;
      logic [49:0] z;
      logic ordy;
      logic ir;
      logic ov;
      logic [4:0] d;
      logic [3:0] lane;
      logic last;
   } vec_t;

   vec_t tv [27];
   int total = 0, bad = 0;

   function automatic logic [49:0] fr(input logic [4:0] base, input logic [4:0] step);
      logic [49:0] f = '0;
      for (int k = 0; k < 10; k++) f[k*5 +: 5] = base + 5'(k) * step;
      return f;
   endfunction

   function automatic vec_t mk(input logic iv, input logic [49:0] z, input logic ordy, input logic ir,
                               input logic ov, input logic [4:0] d, input logic [3:0] lane, input logic last);
      vec_t v;
      v.iv = iv; v.z = z; v.ordy = ordy; v.ir = ir; v.ov = ov; v.d = d; v.lane = lane; v.last = last;
      return v;
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic cyc(input logic iv, input logic [49:0] z, input logic ordy, input logic ir, input logic ov,
                      input logic [4:0] d, input logic [3:0] lane, input logic last, input string tag);
      in_valid = iv; in_z = z; out_ready = ordy;
      @(negedge clk);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
      chk({tag, ".out_data"}, 32'(out_data), 32'(d));
      chk({tag, ".out_lane"}, 32'(out_lane), 32'(lane));
      chk({tag, ".out_last"}, 32'(out_last), 32'(last));
`ifdef WC_Z_PARITY_EN
      chk({tag, ".out_par"}, 32'(out_par), 32'(^d));
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [49:0] f1, fa, fb, fc, fd, fe, fg, fp;
      f1 = fr(5'd1, 5'd1);
      fa = fr(5'h03, 5'd0);
      fb = fr(5'h1c, 5'd0);
      fc = fr(5'h0a, 5'd0);
      fd = fr(5'h10, 5'd1);
      fe = fr(5'h0e, 5'd0);
      fg = fr(5'h11, 5'd0);
      fp = 50'h67;
      tv[0] = mk(1, f1, 1, 1, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) tv[1+k] = mk(0, '0, 1, 1, 1, 5'(k + 1), 4'(k), k == 9);
      tv[11] = mk(0, '0, 1, 1, 0, 0, 0, 0);
      tv[12] = mk(1, f1, 1, 1, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) tv[13+k] = mk(0, '0, 1, 1, 1, 5'(k + 1), 4'(k), 0);
      for (int j = 0; j < 3; j++) tv[17+j] = mk(0, '0, 0, 1, 1, 5'd5, 4'd4, 0);
      for (int k = 4; k < 10; k++) tv[16+k] = mk(0, '0, 1, 1, 1, 5'(k + 1), 4'(k), k == 9);
      tv[26] = mk(0, '0, 1, 1, 0, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      cyc(0, '0, 0, 0, 0, 0, 0, 0, "reset");
      rst = 0;
      for (int i = 0; i < 27; i++)
         cyc(tv[i].iv, tv[i].z, tv[i].ordy, tv[i].ir, tv[i].ov, tv[i].d, tv[i].lane, tv[i].last,
             $sformatf("vec%0d", i));

      cyc(1, fa, 0, 1, 0, 0, 0, 0, "full_pushA");
      cyc(1, fb, 0, 1, 1, 5'h03, 0, 0, "full_pushB");
      cyc(1, fc, 0, 0, 1, 5'h03, 0, 0, "full_reject");
      for (int k = 0; k < 10; k++) cyc(0, '0, 1, 0, 1, 5'h03, 4'(k), k == 9, "drainA");
      for (int k = 0; k < 10; k++) cyc(0, '0, 1, 1, 1, 5'h1c, 4'(k), k == 9, "drainB");
      cyc(0, '0, 1, 1, 0, 0, 0, 0, "drained");

      cyc(1, fd, 1, 1, 0, 0, 0, 0, "pushD");
      for (int k = 0; k < 9; k++) cyc(0, '0, 1, 1, 1, 5'(16 + k), 4'(k), 0, "sendD");
      cyc(1, fc, 1, 1, 1, 5'd25, 4'd9, 1, "pushC_popD");
      cyc(0, '0, 0, 1, 1, 5'h0a, 0, 0, "C_lane0");
      cyc(1, fe, 0, 1, 1, 5'h0a, 0, 0, "pushE");
      cyc(0, '0, 0, 0, 1, 5'h0a, 0, 0, "full_after_E");

      for (int k = 0; k < 6; k++) cyc(0, '0, 1, 0, 1, 5'h0a, 4'(k), 0, "sendC");
      rst = 1;
      cyc(0, '0, 1, 0, 1, 5'h0a, 4'd6, 0, "rst_mid");
      rst = 0;
      cyc(0, '0, 1, 1, 0, 0, 0, 0, "post_rst");
      cyc(1, fg, 1, 1, 0, 0, 0, 0, "pushG");
      for (int k = 0; k < 10; k++) cyc(0, '0, 1, 1, 1, 5'h11, 4'(k), k == 9, "sendG");
      cyc(0, '0, 1, 1, 0, 0, 0, 0, "idleG");

      cyc(1, fp, 1, 1, 0, 0, 0, 0, "pushP");
      cyc(0, '0, 1, 1, 1, 5'h07, 0, 0, "par_lane0");
      cyc(0, '0, 1, 1, 1, 5'h03, 1, 0, "par_lane1");
      for (int k = 2; k < 10; k++) cyc(0, '0, 1, 1, 1, 0, 4'(k), k == 9, "sendP");
      cyc(0, '0, 1, 1, 0, 0, 0, 0, "idleP");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
